count_event_monitor: RTL and testbench

Downstream observer for the free-running up-counter (`q`, `en`, `start` outputs). It tracks successive counter values against a programmable threshold and flags wrap-around, stalls and illegal jumps. Each event is queued in a 2-entry buffer and delivered to a consumer over a valid/ready handshake. It is the event source for the counter's interrupt/logging path.

---
 rtl/count_event_monitor.sv | 170 +++++++++++++++++
 tb/tb_count_event_monitor.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_event_monitor.sv
// Event monitor for a free-running up-counter: threshold, wrap,
// stall and skip detection queued in a 2-entry valid/ready FIFO.
module count_event_monitor #(
  parameter int WIDTH        = 8,
  parameter int STALL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] q,
  input  logic             arm,
  input  logic [WIDTH-1:0] thresh,
  input  logic             clr,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] evt_value,
  output logic [1:0]       state,
  output logic [3:0]       wrap_cnt,
  output logic             drop
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRIP  = 2'd2
  } st_t;

  typedef enum logic [1:0] {
    E_THRESH = 2'd0,
    E_WRAP   = 2'd1,
    E_STALL  = 2'd2,
    E_SKIP   = 2'd3
  } ev_t;

  localparam logic [7:0] SC = 8'(STALL_CYCLES);

  st_t              r_state;
  logic             r_seen;
  logic [WIDTH-1:0] r_q_prev;
  logic [7:0]       r_stall;
  logic [3:0]       r_wc;
  logic             r_drop;

  logic [1:0]       r_code [2];
  logic [WIDTH-1:0] r_val  [2];
  logic             r_rd;
  logic             r_wr;
  logic [1:0]       r_cnt;

  logic             w_active;
  logic [WIDTH-1:0] w_qinc;
  logic             w_skip;
  logic             w_wrap;
  logic             w_thr;
  logic             w_stall;
  logic             w_multi;
  logic             w_push;
  ev_t              w_code;
  logic             w_valid;
  logic             w_pop;
  logic             w_full;
  logic             w_acc;
  logic             w_ovf;

  assign w_active = (r_state != S_IDLE) && r_seen;
  assign w_qinc   = r_q_prev + WIDTH'(1);

  assign w_skip  = w_active && (q != r_q_prev)
                && (q != w_qinc);
  assign w_wrap  = w_active && (&r_q_prev)
                && (q == '0);
  assign w_thr   = w_active && (r_state == S_ARMED)
                && (q == thresh) && (q != r_q_prev);
  // Fires only on the cycle the counter reaches the limit.
  assign w_stall = w_active && !en
                && (r_stall == SC - 8'd1);

  assign w_multi = $countones(
    {w_skip, w_wrap, w_thr, w_stall}) > 1;

  always_comb begin
    w_push = 1'b1;
    w_code = E_SKIP;
    if (w_skip)       w_code = E_SKIP;
    else if (w_wrap)  w_code = E_WRAP;
    else if (w_thr)   w_code = E_THRESH;
    else if (w_stall) w_code = E_STALL;
    else              w_push = 1'b0;
  end

  assign w_valid = (r_cnt != 2'd0);
  assign w_full  = (r_cnt == 2'd2);
  assign w_pop   = w_valid && evt_ready;
  assign w_acc   = w_push && (!w_full || w_pop);
  assign w_ovf   = w_push && !w_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_seen   <= 1'b0;
      r_q_prev <= '0;
      r_stall  <= 8'd0;
      r_wc     <= 4'd0;
      r_drop   <= 1'b0;
    end else begin
      r_seen   <= 1'b1;
      r_q_prev <= q;

      if (!w_active || en)
        r_stall <= 8'd0;
      else if (r_stall != SC)
        r_stall <= r_stall + 8'd1;

      if (w_wrap)
        r_wc <= clr ? 4'd1
              : (r_wc == 4'd15) ? 4'd15
              : r_wc + 4'd1;
      else if (clr)
        r_wc <= 4'd0;

      if (w_multi || w_ovf)
        r_drop <= 1'b1;
      else if (clr)
        r_drop <= 1'b0;

      unique case (r_state)
        S_IDLE:
          if (arm) r_state <= S_ARMED;
        S_ARMED:
          if (!arm)      r_state <= S_IDLE;
          else if (w_thr) r_state <= S_TRIP;
        S_TRIP:
          if (!arm) r_state <= S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_code[0] <= 2'd0;
      r_code[1] <= 2'd0;
      r_val[0]  <= '0;
      r_val[1]  <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_acc) begin
        r_code[r_wr] <= w_code;
        r_val[r_wr]  <= q;
        r_wr         <= ~r_wr;
      end
      if (w_pop)
        r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_acc}
                     - {1'b0, w_pop};
    end
  end

  assign evt_valid = w_valid;
  assign evt_code  = w_valid ? r_code[r_rd] : 2'd0;
  assign evt_value = w_valid ? r_val[r_rd] : '0;
  assign state     = r_state;
  assign wrap_cnt  = r_wc;
  assign drop      = r_drop;

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_count_event_monitor;

  localparam int W    = 8;
  localparam int SCY  = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rstn;
  logic         en;
  logic [W-1:0] q;
  logic         arm;
  logic [W-1:0] thresh;
  logic         clr;
  logic         evt_ready;
  logic         evt_valid;
  logic [1:0]   evt_code;
  logic [W-1:0] evt_value;
  logic [1:0]   state;
  logic [3:0]   wrap_cnt;
  logic         drop;

  count_event_monitor #(
    .WIDTH(W),
    .STALL_CYCLES(SCY)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .en(en),
    .q(q),
    .arm(arm),
    .thresh(thresh),
    .clr(clr),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .evt_value(evt_value),
    .state(state),
    .wrap_cnt(wrap_cnt),
    .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  typedef struct {
    int code;
    int value;
  } ev_s;

  ev_s m_q[$];
  int  m_state;
  bit  m_seen;
  int  m_qprev;
  int  m_stall;
  int  m_wc;
  bit  m_drop;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = 0;
    m_seen  = 0;
    m_qprev = 0;
    m_stall = 0;
    m_wc    = 0;
    m_drop  = 0;
  endtask

  // One rising edge worth of behaviour, from the event rules.
  task automatic model_step();
    int  qi, nxt, nev, code;
    bit  act, skp, wrp, thr, stl, pop, lost;
    ev_s e;
    qi   = int'(q);
    nxt  = (m_qprev + 1) % (MAXV + 1);
    act  = (m_state != 0) && m_seen;
    skp  = act && qi != m_qprev && qi != nxt;
    wrp  = act && m_qprev == MAXV && qi == 0;
    thr  = act && m_state == 1 && qi == int'(thresh)
        && qi != m_qprev;
    stl  = 0;
    if (!act || en) m_stall = 0;
    else if (m_stall < SCY) begin
      m_stall++;
      stl = (m_stall == SCY);
    end
    nev  = int'(skp) + int'(wrp) + int'(thr) + int'(stl);
    code = skp ? 3 : wrp ? 1 : thr ? 0 : stl ? 2 : -1;
    lost = (nev > 1);
    pop  = (m_q.size() > 0) && evt_ready;
    if (pop) void'(m_q.pop_front());
    if (code >= 0) begin
      if (m_q.size() < 2) begin
        e.code  = code;
        e.value = qi;
        m_q.push_back(e);
      end else lost = 1;
    end
    if (clr) begin
      m_drop = 0;
      m_wc   = 0;
    end
    if (lost) m_drop = 1;
    if (wrp && m_wc < 15) m_wc++;
    if (m_state != 0 && !arm) m_state = 0;
    else if (m_state == 0 && arm) m_state = 1;
    else if (m_state == 1 && thr) m_state = 2;
    m_seen  = 1;
    m_qprev = qi;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(evt_valid),
        32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk({tag, "_code"}, 32'(evt_code), m_q[0].code);
      chk({tag, "_value"}, 32'(evt_value), m_q[0].value);
    end
    chk({tag, "_state"}, 32'(state), m_state);
    chk({tag, "_wrap"}, 32'(wrap_cnt), m_wc);
    chk({tag, "_drop"}, 32'(drop), 32'(m_drop));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic drv(input bit a, input bit e,
                     input int qq, input bit r);
    arm       = a;
    en        = e;
    q         = W'(qq);
    evt_ready = r;
  endtask

  task automatic hchk(input string tag, input bit v,
                      input int c, input int val);
    chk({tag, "_v"}, 32'(evt_valid), 32'(v));
    if (v) begin
      chk({tag, "_c"}, 32'(evt_code), c);
      chk({tag, "_x"}, 32'(evt_value), val);
    end
  endtask

  typedef struct {
    bit   arm;
    bit   en;
    int   q;
    int   th;
    bit   ev;
    int   code;
    int   val;
    int   st;
  } vec_t;

  vec_t tbl[8];

  initial begin
    n_chk = 0;
    n_err = 0;

    tbl[0] = '{1, 1, 0, 5, 0, 0, 0, 1};
    tbl[1] = '{1, 1, 1, 5, 0, 0, 0, 1};
    tbl[2] = '{1, 1, 2, 5, 0, 0, 0, 1};
    tbl[3] = '{1, 1, 3, 5, 0, 0, 0, 1};
    tbl[4] = '{1, 1, 4, 5, 0, 0, 0, 1};
    tbl[5] = '{1, 1, 5, 5, 1, 0, 5, 2};
    tbl[6] = '{1, 1, 6, 5, 0, 0, 0, 2};
    tbl[7] = '{1, 1, 7, 5, 0, 0, 0, 2};

    rstn      = 1'b0;
    en        = 1'b0;
    q         = '0;
    arm       = 1'b0;
    thresh    = '0;
    clr       = 1'b0;
    evt_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    chk("reset_code", 32'(evt_code), 0);
    chk("reset_value", 32'(evt_value), 0);
    rstn = 1'b1;

    // Threshold trip while counting from zero
    foreach (tbl[i]) begin
      drv(tbl[i].arm, tbl[i].en, tbl[i].q, 1'b1);
      thresh = W'(tbl[i].th);
      tick("tbl");
      hchk("tbl", tbl[i].ev, tbl[i].code, tbl[i].val);
      chk("tbl_state", 32'(state), tbl[i].st);
    end

    // Wrap colliding with threshold at zero
    drv(0, 1, 8, 1);    tick("w0");
    drv(0, 1, 'hFD, 1); tick("w1");
    thresh = 8'h00;
    drv(1, 1, 'hFD, 1); tick("w2");
    drv(1, 1, 'hFE, 1); tick("w3");
    drv(1, 1, 'hFF, 1); tick("w4");
    drv(1, 1, 'h00, 1); tick("w5");
    hchk("wrap", 1, 1, 0);
    chk("wrap_drop", 32'(drop), 1);
    chk("wrap_cnt", 32'(wrap_cnt), 1);
    chk("wrap_state", 32'(state), 2);

    // Stall: six low cycles give one event
    for (int i = 1; i <= 6; i++) begin
      drv(1, 0, 0, 1);
      tick("st");
      if (i == 3) hchk("stall_pre", 0, 0, 0);
      if (i == 4) hchk("stall_hit", 1, 2, 0);
      if (i >= 5) hchk("stall_hold", 0, 0, 0);
    end
    drv(1, 1, 1, 1); tick("st_up");
    for (int i = 1; i <= 4; i++) begin
      drv(1, 0, 1, 1);
      tick("st2");
      if (i == 3) hchk("stall2_pre", 0, 0, 0);
      if (i == 4) hchk("stall2_hit", 1, 2, 1);
    end

    // Skips
    drv(1, 1, 'h10, 1); tick("sk0");
    hchk("skip10", 1, 3, 'h10);
    drv(1, 1, 'h20, 1); tick("sk1");
    hchk("skip20", 1, 3, 'h20);

    // Backpressure: third event is lost
    clr = 1'b1;
    drv(1, 1, 'h20, 1); tick("clr");
    clr = 1'b0;
    chk("clr_drop", 32'(drop), 0);
    chk("clr_wrap", 32'(wrap_cnt), 0);
    drv(1, 1, 'h30, 0); tick("bp0");
    drv(1, 1, 'h40, 0); tick("bp1");
    hchk("bp_hold", 1, 3, 'h30);
    chk("bp_drop0", 32'(drop), 0);
    drv(1, 1, 'h50, 0); tick("bp2");
    hchk("bp_full", 1, 3, 'h30);
    chk("bp_drop1", 32'(drop), 1);
    drv(1, 1, 'h50, 1); tick("bp3");
    hchk("bp_d1", 1, 3, 'h40);
    drv(1, 1, 'h50, 1); tick("bp4");
    hchk("bp_d2", 0, 0, 0);

    // Push colliding with pop while full
    clr = 1'b1;
    drv(1, 1, 'h60, 0); tick("co0");
    clr = 1'b0;
    drv(1, 1, 'h70, 0); tick("co1");
    drv(1, 1, 'h80, 1); tick("co2");
    hchk("coll_head", 1, 3, 'h70);
    chk("coll_drop", 32'(drop), 0);
    drv(1, 1, 'h80, 1); tick("co3");
    hchk("coll_tail", 1, 3, 'h80);
    drv(1, 1, 'h80, 1); tick("co4");
    hchk("coll_empty", 0, 0, 0);

    // Async reset with two events queued
    drv(1, 1, 'h90, 0); tick("rs0");
    drv(1, 1, 'hA0, 0); tick("rs1");
    hchk("rs_full", 1, 3, 'h90);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("rs_async_valid", 32'(evt_valid), 0);
    drv(1, 1, 0, 1);
    @(posedge clk);
    @(negedge clk);
    check_model("rs_hold");
    chk("rs_state", 32'(state), 0);
    chk("rs_wrap", 32'(wrap_cnt), 0);
    rstn = 1'b1;
    tick("rs_rel");
    hchk("rs_first", 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      arm = ($urandom_range(0, 19) != 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0)
        q = W'($urandom);
      else if (en)
        q = q + W'(1);
      if ($urandom_range(0, 15) == 0)
        thresh = q + W'($urandom_range(1, 8));
      clr       = ($urandom_range(0, 31) == 0);
      evt_ready = ($urandom_range(0, 2) != 0);
      tick("rnd");
      if (i % 700 == 699) begin
        rstn = 1'b0;
        model_reset();
        #1;
        check_model("rnd_rst");
        @(negedge clk);
        rstn = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
